// File: rtl/fp_div_pkg.sv
// Shared definitions for the iterative floating-point divider.
// Holds the rounding-mode and state encodings, the exception-flag and
// operand-class structs, the canonical quiet-NaN pieces, and the
// operand classifier used when the divider decodes its operands.
package fp_div_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_t;

  // Divider FSM state encodings.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PREP  = 3'd1;
  localparam state_t ST_ITER  = 3'd2;
  localparam state_t ST_ROUND = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  typedef struct packed {
    logic invalid;
    logic divbyzero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
    logic denorm;
  } fp_class_t;

  // Canonical qNaN: sign 0, exponent all ones, only the fraction MSB set.
  localparam logic QNAN_SIGN     = 1'b0;
  localparam logic QNAN_FRAC_MSB = 1'b1;

  // Encodings 4-7 are not defined and fall back to round-to-nearest-even.
  function automatic rm_t rm_decode(input logic [2:0] rm);
    case (rm)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      default: return RM_RNE;
    endcase
  endfunction

  function automatic fp_class_t fp_classify(input logic exp_ones, input logic exp_zero,
                                            input logic frac_zero, input logic frac_msb);
    fp_class_t c;
    c.zero   = exp_zero & frac_zero;
    c.denorm = exp_zero & ~frac_zero;
    c.inf    = exp_ones & frac_zero;
    c.nan    = exp_ones & ~frac_zero;
    c.snan   = exp_ones & ~frac_zero & ~frac_msb;
    return c;
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// Restoring mantissa divider retiring QB quotient bits per enabled cycle.
// Ports:
//   clk, rst (sync, active-high), ce (clock enable)
//   ld        - load dividend/divisor and start N iterations
//   dividend  - WD-bit normalised mantissa (MSB set)
//   divisor   - WD-bit normalised mantissa (MSB set)
//   q         - QN-bit quotient, MSB has weight 2^0
//   rem       - partial remainder after the last step (nonzero => inexact)
//   done      - high during the final iteration; q/rem are final after that edge
module fp_div_core #(
  parameter int WD = 37,
  parameter int N  = 39,
  parameter int QB = 1,
  parameter int QN = 39
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          ld,
  input  logic [WD-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic [QN-1:0] q,
  output logic [WD:0]   rem,
  output logic          done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);

  logic [WD-1:0] dsr;
  logic [WD:0]   rem_nx;
  logic [QN-1:0] q_nx;
  logic [CW-1:0] cnt;

  // QB restoring steps: the remainder always stays below twice the divisor,
  // so one extra bit of headroom is enough.
  always_comb begin
    rem_nx = rem;
    q_nx   = q;
    for (int i = 0; i < QB; i++) begin
      if (rem_nx >= {1'b0, dsr}) begin
        q_nx   = {q_nx[QN-2:0], 1'b1};
        rem_nx = (rem_nx - {1'b0, dsr}) << 1;
      end else begin
        q_nx   = {q_nx[QN-2:0], 1'b0};
        rem_nx = rem_nx << 1;
      end
    end
  end

  // Operand load and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= {(WD+1){1'b0}};
      dsr <= {WD{1'b0}};
      q   <= {QN{1'b0}};
      cnt <= {CW{1'b0}};
    end else if (ce) begin
      if (ld) begin
        rem <= {1'b0, dividend};
        dsr <= divisor;
        q   <= {QN{1'b0}};
        cnt <= CNT_LOAD;
      end else if (cnt != {CW{1'b0}}) begin
        rem <= rem_nx;
        q   <= q_nx;
        cnt <= cnt - CNT_ONE;
      end else begin
        rem <= rem;
        q   <= q;
        cnt <= cnt;
      end
    end else begin
      rem <= rem;
      q   <= q;
      cnt <= cnt;
    end
  end

  assign done = (cnt == CNT_ONE);

endmodule

// File: rtl/fp_divide_iter.sv
// Iterative IEEE-754-style divider with flush-to-zero denormals, four
// rounding modes and full exception flags; one operation in flight.
// Ports:
//   clk, rst (sync, active-high), ce (clock enable for all state)
//   req_valid/req_ready, a, b, rm - request handshake and operands
//   resp_valid/resp_ready, o, flags - response handshake, result and
//   {invalid, divbyzero, overflow, underflow, inexact}
module fp_divide_iter
  import fp_div_pkg::*;
#(
  parameter int EW = 11,
  parameter int FW = 36,
  parameter int QB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [EW+FW:0]   a,
  input  logic [EW+FW:0]   b,
  input  logic [2:0]       rm,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [EW+FW:0]   o,
  output logic [4:0]       flags
);

  localparam int W  = 1 + EW + FW;
  localparam int Q  = FW + 3;
  localparam int N  = (Q + QB - 1) / QB;
  localparam int QN = N * QB;
  localparam int XW = EW + 2;
  localparam int MW = FW + 1;
  localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  // Quotient bits beyond Q (only when QB does not divide Q) feed sticky.
  localparam logic [QN-1:0] XMASK = QN'((1 << (QN - Q)) - 1);

  state_t                state;
  logic [W-1:0]          a_q, b_q, o_q;
  logic [2:0]            rm_q;
  logic                  sign_q;
  logic signed [XW-1:0]  exp_q;
  fp_flags_t             flags_q;

  logic                  sa, sb, sign;
  logic [EW-1:0]         ea, eb;
  logic [FW-1:0]         fa, fb;
  fp_class_t             ca, cb;
  logic                  za, zb;
  logic signed [XW-1:0]  e_prep;
  logic                  is_special;
  logic [W-1:0]          spec_o, nan_src;
  fp_flags_t             spec_f;

  logic [QN-1:0]         q_all;
  logic [MW:0]           rem;
  logic                  core_done;
  logic                  core_ld;

  logic [Q-1:0]          q_top;
  logic [MW-1:0]         mant;
  logic                  guard, sticky, sticky_x, inc, carry, to_inf;
  logic [MW:0]           rounded;
  logic [FW-1:0]         frac_r;
  logic signed [XW-1:0]  e_n, e_r;
  rm_t                   rm_dec;
  logic [W-1:0]          round_o;
  fp_flags_t             round_f;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign ca   = fp_classify(&ea, ~|ea, ~|fa, fa[FW-1]);
  assign cb   = fp_classify(&eb, ~|eb, ~|fb, fb[FW-1]);
  assign za   = ca.zero | ca.denorm;
  assign zb   = cb.zero | cb.denorm;
  assign sign = sa ^ sb;
  assign e_prep = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;
  assign rm_dec = rm_decode(rm_q);

  // Special-operand results, highest priority first.
  always_comb begin
    is_special = 1'b1;
    spec_o     = {W{1'b0}};
    spec_f     = fp_flags_t'(5'b0);
    nan_src    = ca.nan ? a_q : b_q;
    if (ca.nan | cb.nan) begin
      spec_o         = nan_src;
      spec_o[FW-1]   = 1'b1;
      spec_f.invalid = ca.nan ? ca.snan : cb.snan;
    end else if ((za & zb) | (ca.inf & cb.inf)) begin
      spec_o         = {QNAN_SIGN, {EW{1'b1}}, QNAN_FRAC_MSB, {(FW-1){1'b0}}};
      spec_f.invalid = 1'b1;
    end else if (zb & ~ca.inf) begin
      spec_o           = {sign, {EW{1'b1}}, {FW{1'b0}}};
      spec_f.divbyzero = 1'b1;
    end else if (ca.inf) begin
      spec_o = {sign, {EW{1'b1}}, {FW{1'b0}}};
    end else if (cb.inf | za) begin
      spec_o = {sign, {(EW+FW){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  assign core_ld = (state == ST_PREP) & ~is_special;

  fp_div_core #(.WD(MW), .N(N), .QB(QB), .QN(QN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .ld       (core_ld),
    .dividend ({1'b1, fa}),
    .divisor  ({1'b1, fb}),
    .q        (q_all),
    .rem      (rem),
    .done     (core_done)
  );

  // Normalise, round and range-check the quotient.
  always_comb begin
    q_top    = q_all[QN-1 -: Q];
    sticky_x = (|(q_all & XMASK)) | (|rem);
    if (q_top[Q-1]) begin
      mant   = q_top[Q-1:2];
      guard  = q_top[1];
      sticky = q_top[0] | sticky_x;
      e_n    = exp_q;
    end else begin
      mant   = q_top[Q-2:1];
      guard  = q_top[0];
      sticky = sticky_x;
      e_n    = exp_q - ONE_X;
    end
    case (rm_dec)
      RM_RNE:  inc = guard & (sticky | mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & (guard | sticky);
      RM_RUP:  inc = ~sign_q & (guard | sticky);
      default: inc = 1'b0;
    endcase
    rounded = {1'b0, mant} + {{MW{1'b0}}, inc};
    carry   = rounded[MW];
    // On carry-out the fraction is all zeros either way; take it above the
    // hidden bit so the slice tracks the renormalised mantissa.
    frac_r  = carry ? rounded[FW:1] : rounded[FW-1:0];
    e_r     = e_n + $signed({{(XW-1){1'b0}}, carry});
    to_inf  = (rm_dec == RM_RNE) | ((rm_dec == RM_RUP) & ~sign_q) |
              ((rm_dec == RM_RDN) & sign_q);
    round_f = fp_flags_t'(5'b0);
    if (e_r[XW-1] || (e_r == {XW{1'b0}})) begin
      round_o           = {sign_q, {(EW+FW){1'b0}}};
      round_f.underflow = 1'b1;
      round_f.inexact   = 1'b1;
    end else if (e_r >= EMAX_X) begin
      round_o          = to_inf ? {sign_q, {EW{1'b1}}, {FW{1'b0}}}
                                : {sign_q, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
      round_f.overflow = 1'b1;
      round_f.inexact  = 1'b1;
    end else begin
      round_o         = {sign_q, e_r[EW-1:0], frac_r};
      round_f.inexact = guard | sticky;
    end
  end

  // Control FSM with operand, exponent and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      rm_q    <= 3'd0;
      sign_q  <= 1'b0;
      exp_q   <= {XW{1'b0}};
      o_q     <= {W{1'b0}};
      flags_q <= fp_flags_t'(5'b0);
    end else if (ce) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_q   <= a;
            b_q   <= b;
            rm_q  <= rm;
            state <= ST_PREP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PREP: begin
          sign_q <= sign;
          exp_q  <= e_prep;
          if (is_special) begin
            o_q     <= spec_o;
            flags_q <= spec_f;
            state   <= ST_RESP;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (core_done) begin
            state <= ST_ROUND;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ROUND: begin
          o_q     <= round_o;
          flags_q <= round_f;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end else begin
      state <= state;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign o          = o_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_fp_divide_iter.sv
// Directed self-checking bench for fp_divide_iter (default FP48 format).
module tb_fp_divide_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] a = 48'h0;
  logic [47:0] b = 48'h0;
  logic [2:0]  rm = 3'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [47:0] o;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  fp_divide_iter dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .rm         (rm),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .o          (o),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  // Present one request for a single edge; the divider is idle when called.
  task automatic do_req(input logic [47:0] ta, input logic [47:0] tb_v, input logic [2:0] trm);
    a = ta;
    b = tb_v;
    rm = trm;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until resp_valid (cycle 1 = first one).
  task automatic wait_resp(output int cycles);
    cycles = 1;
    while (!resp_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic take_resp();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (o !== 48'h0) begin n_fail++; $display("FAIL reset_o: got %h expected 000000000000", o); end
    n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", flags); end
  endtask

  task automatic test_divide();
    do_req(48'h401800000000, 48'h400000000000, 3'd0);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL busy_req_ready: got %b expected 0", req_ready); end
    wait_resp(lat);
    n_checks++; if (lat !== 42) begin n_fail++; $display("FAIL six_by_two_latency: got %0d expected 42", lat); end
    n_checks++; if (o !== 48'h400800000000) begin n_fail++; $display("FAIL six_by_two_o: got %h expected 400800000000", o); end
    n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL six_by_two_flags: got %b expected 00000", flags); end
    take_resp();

    do_req(48'h3FF000000000, 48'h400800000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (lat !== 42) begin n_fail++; $display("FAIL third_latency: got %0d expected 42", lat); end
    n_checks++; if (o !== 48'h3FD555555555) begin n_fail++; $display("FAIL third_rne_o: got %h expected 3fd555555555", o); end
    n_checks++; if (flags !== 5'b00001) begin n_fail++; $display("FAIL third_rne_flags: got %b expected 00001", flags); end
    take_resp();

    do_req(48'h3FF000000000, 48'h400800000000, 3'd3);
    wait_resp(lat);
    n_checks++; if (o !== 48'h3FD555555556) begin n_fail++; $display("FAIL third_rup_o: got %h expected 3fd555555556", o); end
    n_checks++; if (flags !== 5'b00001) begin n_fail++; $display("FAIL third_rup_flags: got %b expected 00001", flags); end
    take_resp();

    do_req(48'hBFF000000000, 48'h400800000000, 3'd3);
    wait_resp(lat);
    n_checks++; if (o !== 48'hBFD555555555) begin n_fail++; $display("FAIL neg_third_rup_o: got %h expected bfd555555555", o); end
    take_resp();

    do_req(48'hBFF000000000, 48'h400800000000, 3'd2);
    wait_resp(lat);
    n_checks++; if (o !== 48'hBFD555555556) begin n_fail++; $display("FAIL neg_third_rdn_o: got %h expected bfd555555556", o); end
    take_resp();
  endtask

  task automatic test_specials();
    do_req(48'h3FF000000000, 48'h000000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 2", lat); end
    n_checks++; if (o !== 48'h7FF000000000) begin n_fail++; $display("FAIL divzero_o: got %h expected 7ff000000000", o); end
    n_checks++; if (flags !== 5'b01000) begin n_fail++; $display("FAIL divzero_flags: got %b expected 01000", flags); end
    take_resp();

    do_req(48'h000000000000, 48'h000000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL zero_zero_latency: got %0d expected 2", lat); end
    n_checks++; if (o !== 48'h7FF800000000) begin n_fail++; $display("FAIL zero_zero_o: got %h expected 7ff800000000", o); end
    n_checks++; if (flags !== 5'b10000) begin n_fail++; $display("FAIL zero_zero_flags: got %b expected 10000", flags); end
    take_resp();

    // Signalling NaN dividend: payload kept, quiet bit set, invalid raised.
    do_req(48'h7FF000000123, 48'h3FF000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (o !== 48'h7FF800000123) begin n_fail++; $display("FAIL snan_o: got %h expected 7ff800000123", o); end
    n_checks++; if (flags !== 5'b10000) begin n_fail++; $display("FAIL snan_flags: got %b expected 10000", flags); end
    take_resp();
  endtask

  task automatic test_overflow();
    do_req(48'h7FEFFFFFFFFF, 48'h3FE000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (o !== 48'h7FF000000000) begin n_fail++; $display("FAIL ovf_rne_o: got %h expected 7ff000000000", o); end
    n_checks++; if (flags !== 5'b00101) begin n_fail++; $display("FAIL ovf_rne_flags: got %b expected 00101", flags); end
    take_resp();

    do_req(48'h7FEFFFFFFFFF, 48'h3FE000000000, 3'd1);
    wait_resp(lat);
    n_checks++; if (o !== 48'h7FEFFFFFFFFF) begin n_fail++; $display("FAIL ovf_rtz_o: got %h expected 7fefffffffff", o); end
    n_checks++; if (flags !== 5'b00101) begin n_fail++; $display("FAIL ovf_rtz_flags: got %b expected 00101", flags); end
    take_resp();
  endtask

  task automatic test_backpressure();
    int bad;
    resp_ready = 1'b0;
    do_req(48'h401800000000, 48'h400000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_valid: got %b expected 1", resp_valid); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (o !== 48'h400800000000 || flags !== 5'b00000 || resp_valid !== 1'b1 || req_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    resp_ready = 1'b1;
    take_resp();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    do_req(48'h3FF000000000, 48'h000000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (o !== 48'h7FF000000000) begin n_fail++; $display("FAIL bp_next_o: got %h expected 7ff000000000", o); end
    take_resp();
  endtask

  task automatic test_reset_iter();
    int seen;
    do_req(48'h401800000000, 48'h400000000000, 3'd0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_iter_valid: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_iter_ready: got %b expected 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_iter_no_resp: got %0d valid cycles expected 0", seen); end
    do_req(48'h401800000000, 48'h400000000000, 3'd0);
    wait_resp(lat);
    n_checks++; if (lat !== 42) begin n_fail++; $display("FAIL rst_iter_latency: got %0d expected 42", lat); end
    n_checks++; if (o !== 48'h400800000000) begin n_fail++; $display("FAIL rst_iter_o: got %h expected 400800000000", o); end
    take_resp();
  endtask

  initial begin
    test_reset();
    test_divide();
    test_specials();
    test_overflow();
    test_backpressure();
    test_reset_iter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
